uart_rx: RTL and testbench

Serial receiver for the UART link: recovers 8N1 frames from the asynchronous `RX` line and presents each received byte on a parallel bus with a ready flag. It is the receive-side counterpart of the existing UART transmitter and uses the same bit period, so a looped-back TX→RX pair interoperates directly. It sits between the board RX pin and any byte consumer.

---
 rtl/uart_rx.sv | 130 +++++++++++++
 tb/tb_uart_rx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// uart_rx : 8N1 UART receiver, parallel byte out with rdy/frm_err/ovr flags
// Rev 1.0
// ============================================================================
module uart_rx #(
  parameter int BAUD_DIV = 108
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] HALF_M1 = BW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] FULL_M1 = BW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_s_q, rx_s_d_q;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          rdy_q, rdy_d;
  logic          frm_q, frm_d;
  logic          ovr_q, ovr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_s_d_q  <= 1'b1;
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      rdy_q     <= 1'b0;
      frm_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
      rx_s_d_q  <= rx_s_q;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      rdy_q     <= rdy_d;
      frm_q     <= frm_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    rdy_d   = rdy_q;
    frm_d   = frm_q;
    ovr_d   = ovr_q;

    // Consumer clear first so a completing frame below overrides it.
    if (clr_rdy) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_s_d_q && !rx_s_q) begin
          state_d = S_START;
          baud_d  = '0;
        end
      end
      S_START: begin
        if (baud_q == HALF_M1) begin
          baud_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (baud_q == FULL_M1) begin
          baud_d  = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_q == FULL_M1) begin
          baud_d  = '0;
          state_d = S_IDLE;
          data_d  = shift_q;
          rdy_d   = 1'b1;
          frm_d   = ~rx_s_q;
          if (rdy_q) ovr_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_data = data_q;
  assign rdy     = rdy_q;
  assign frm_err = frm_q;
  assign ovr     = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// tb_uart_rx : directed, table-driven bench for uart_rx at 108 clocks/bit
// Rev 1.0
// ============================================================================
module tb_uart_rx;

  localparam int BD = 108;

  logic       clk;
  logic       rst;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr;

  int n_checks;
  int n_fail;

  uart_rx #(.BAUD_DIV(BD)) dut (
    .clk     (clk),
    .rst     (rst),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err),
    .ovr     (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         clr_at;
    int         gap;
    logic       pre_rdy;
    logic [7:0] exp_data;
    logic       exp_frm;
    logic       exp_ovr;
    logic       end_rdy;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one frame starting at a negedge; cycle i counts negedges from the
  // start-bit fall. Completion is visible at i=1029 for BD=108.
  task automatic drive_frame(input logic [7:0] d, input logic stop, input int clr_at,
                             input int ncyc, output logic pre_rdy, output logic post_rdy,
                             output logic [7:0] post_data, output logic post_frm,
                             output logic post_ovr);
    int idx;
    pre_rdy   = 1'b0;
    post_rdy  = 1'b0;
    post_data = 8'h00;
    post_frm  = 1'b0;
    post_ovr  = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (i == 1028) pre_rdy = rdy;
      if (i == 1029) begin
        post_rdy  = rdy;
        post_data = rx_data;
        post_frm  = frm_err;
        post_ovr  = ovr;
      end
      idx = i / BD;
      if (idx == 0)      RX = 1'b0;
      else if (idx <= 8) RX = d[idx-1];
      else if (idx == 9) RX = stop;
      else               RX = 1'b1;
      clr_rdy = (i == clr_at);
    end
  endtask

  task automatic idle(input int n, output int rdy_seen);
    rdy_seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      RX      = 1'b1;
      clr_rdy = 1'b0;
      if (rdy) rdy_seen++;
    end
  endtask

  task automatic apply_vec(input int k);
    logic       pre_r, post_r, post_f, post_o;
    logic [7:0] post_d;
    int         seen;
    drive_frame(vecs[k].data, vecs[k].stop, vecs[k].clr_at, 10 * BD,
                pre_r, post_r, post_d, post_f, post_o);
    if (vecs[k].gap > 0) idle(vecs[k].gap, seen);
    check($sformatf("vec%0d rdy_before_done", k), 32'(pre_r), 32'(vecs[k].pre_rdy));
    check($sformatf("vec%0d rdy_at_done", k), 32'(post_r), 32'd1);
    check($sformatf("vec%0d rx_data", k), 32'(post_d), 32'(vecs[k].exp_data));
    check($sformatf("vec%0d frm_err", k), 32'(post_f), 32'(vecs[k].exp_frm));
    check($sformatf("vec%0d ovr", k), 32'(post_o), 32'(vecs[k].exp_ovr));
    check($sformatf("vec%0d rdy_at_end", k), 32'(rdy), 32'(vecs[k].end_rdy));
  endtask

  initial begin
    logic       pre_r, post_r, post_f, post_o;
    logic [7:0] post_d;
    int         seen;

    n_checks = 0;
    n_fail   = 0;

    //           data   stop  clr   gap pre   exp    frm   ovr   end
    vecs[0] = '{8'hA5, 1'b1, -1,   50, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'h00, 1'b1, 1040, 0,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1040, 0,  1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h55, 1'b1, 1040, 0,  1'b0, 8'h55, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 1'b1, 1040, 50, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h3C, 1'b0, 1040, 50, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h11, 1'b1, -1,   50, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{8'h22, 1'b1, -1,   50, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{8'h33, 1'b1, 1028, 50, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1};

    // Reset
    rst     = 1'b1;
    RX      = 1'b1;
    clr_rdy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset rx_data", 32'(rx_data), 32'h00);
    check("reset rdy", 32'(rdy), 32'd0);
    check("reset frm_err", 32'(frm_err), 32'd0);
    check("reset ovr", 32'(ovr), 32'd0);
    idle(2000, seen);
    check("idle no rdy", 32'(seen), 32'd0);

    // 20-cycle glitch is a false start
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      RX = 1'b0;
    end
    idle(1500, seen);
    check("glitch no rdy", 32'(seen), 32'd0);
    check("glitch rx_data", 32'(rx_data), 32'h00);

    // Single frame with exact completion timing, then clr_rdy pulse
    apply_vec(0);
    @(negedge clk);
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    check("clr rdy", 32'(rdy), 32'd0);
    check("clr rx_data held", 32'(rx_data), 32'hA5);

    // Loopback, framing error, overrun, clr/complete collision
    for (int k = 1; k < 9; k++) apply_vec(k);

    // Mid-frame reset during data bit 4
    drive_frame(8'hC3, 1'b1, -1, 5 * BD + 50, pre_r, post_r, post_d, post_f, post_o);
    @(negedge clk);
    rst = 1'b1;
    RX  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("midrst rdy", 32'(rdy), 32'd0);
    check("midrst rx_data", 32'(rx_data), 32'h00);
    check("midrst ovr", 32'(ovr), 32'd0);
    idle(1500, seen);
    check("midrst no rdy", 32'(seen), 32'd0);
    drive_frame(8'h7E, 1'b1, -1, 10 * BD, pre_r, post_r, post_d, post_f, post_o);
    check("after rst rdy_before_done", 32'(pre_r), 32'd0);
    check("after rst rdy_at_done", 32'(post_r), 32'd1);
    check("after rst rx_data", 32'(post_d), 32'h7E);
    check("after rst frm_err", 32'(post_f), 32'd0);
    check("after rst ovr", 32'(post_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
